cht_lane_unshift: RTL and testbench
===================================

// Module: cht_lane_unshift
// PURPOSE
// - Sequential inverse of the cht one-position lane shifter: takes a W-bit word shifted by
//   STEPS positions in direction DIR and shifts it back one lane per clock, refilling vacated lanes.
// - Sits downstream of the combinational shift network; valid/ready on both sides.
// - A global active-high hold freezes all state, the sequential counterpart of the network's lane disable.
// PARAMETERS
// - W          36  lane word width, >= 2
// - MAX_STEPS  8   largest shift count; larger requests are clamped to MAX_STEPS
// - SW         $clog2(MAX_STEPS+1)  step-count width (derived, do not override)
// PORTS
// - pclk       in   1   clock, rising edge
// - prst_n     in   1   reset, asynchronous assert, active-low
// - phold      in   1   1 = freeze FSM, counter, data, outputs; handshakes stall
// - pin_valid  in   1   input word valid
// - pin_ready  out  1   block can accept; high only in IDLE with phold=0
// - pin_data   in   W   shifted word
// - pin_dir    in   1   forward direction: 1 = shifted toward lane 0, 0 = toward lane W-1
// - pin_steps  in   SW  forward shift count
// - pin_fill   in   1   bit inserted into each vacated lane during the unshift
// - pin_par    in   1   even parity of pin_data (used only with CHT_UNSHIFT_PARITY_EN)
// - pout_valid out  1   restored word valid
// - pout_ready in   1   consumer accepts
// - pout_data  out  W   restored word
// - pout_err   out  1   parity error flag for pout_data
// BEHAVIOUR
// - Reset: state=IDLE, count=0, data=0, pin_ready=1 after release, pout_valid=0, pout_data=0, pout_err=0.
// - FSM IDLE -> SHIFT -> DONE -> IDLE.
// - IDLE: accept on pin_valid & pin_ready. Latch data/dir/fill.
//   count = min(pin_steps, MAX_STEPS). Next state is SHIFT, or DONE when count=0.
// - SHIFT: one lane per edge.
//   - dir=1: data <= {data[W-2:0], fill}.
//   - dir=0: data <= {fill, data[W-1:1]}.
//   - count decrements. The edge that makes count 0 moves to DONE.
// - DONE: pout_valid=1, pout_data stable. Leave to IDLE on pout_valid & pout_ready.
//   No accept in the same cycle; pin_ready rises the following cycle.
// - Latency: with accept at edge E, pout_valid first high in the cycle after edge E+count
//   (count=0: cycle after E). Throughput is one word per count+2 cycles.
// - phold=1 overrides everything except reset. No state, count or data changes.
//   pin_ready forced 0; pout_valid holds its value but a transfer does not complete.
// - prst_n low mid-SHIFT/DONE: immediate return to the reset values; the in-flight word is dropped, no output.
// - Bits shifted out are lost. Only lanes never vacated by the forward shift are restored exactly.
// CONFIGURATION
// - CHT_UNSHIFT_PARITY_EN defined:
//   - On accept, latch err = ^pin_data ^ pin_par.
//   - pout_err = err while in DONE; cleared when the word leaves.
// - Macro undefined: pin_par ignored, pout_err tied 0, no parity flop.
// STRUCTURE
// - Package cht_unshift_pkg: state enum {IDLE, SHIFT, DONE} (2-bit), DIR_DOWN=1'b1 / DIR_UP=1'b0, clamp function.
// - One sub-module, cht_lane_step: combinational single-lane shift (data, dir, fill) -> data.
//   Instantiated once; the FSM/counter wrapper owns all flops.
// TESTING
// - Reset: prst_n=0 mid-SHIFT -> pout_valid=0, pout_data=0 at once; pin_ready=1 the first cycle after release.
// - W=36, data=36'h0_0000_000F, dir=1, steps=4, fill=0 -> pout_data=36'h0_0000_00F0,
//   pout_valid in the cycle after edge E+4.
// - steps=0, data=36'hA_5A5A_5A5A -> same word, pout_valid in the cycle after E; pin_ready=0 until 1 cycle after drain.
// - steps=15 (> MAX_STEPS=8), dir=0, fill=1, data=0 -> pout_data=36'hF_F000_0000 after 8 shifts.
// - Backpressure: pout_ready=0 for 5 cycles in DONE -> data stable, pin_ready=0. Then phold=1 for 3 cycles
//   mid-SHIFT -> count frozen, total latency +3.
// - PARITY_EN: data=36'h1, pin_par=0 -> pout_err=1. Same with pin_par=1 -> pout_err=0.
//   Macro off -> pout_err=0 for both.

Source files
------------

// File: rtl/cht_unshift_pkg.sv
// Shared types and helpers for the cht lane unshifter: FSM state encoding,
// shift-direction constants and the step-count clamp.
package cht_unshift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Direction of the forward shift being undone.
    localparam logic DIR_DOWN = 1'b1;
    localparam logic DIR_UP   = 1'b0;

    function automatic int unsigned clamp_steps(input int unsigned steps,
                                                input int unsigned max_steps);
        return (steps > max_steps) ? max_steps : steps;
    endfunction

endpackage

// File: rtl/cht_lane_step.sv
// Combinational single-lane shift used by the unshifter: moves the word one lane
// opposite to the forward direction and inserts the fill bit into the vacated lane.
module cht_lane_step
    import cht_unshift_pkg::*;
#(
    parameter int unsigned W = 36
) (
    input  logic [W-1:0] data_i,
    input  logic         dir_i,
    input  logic         fill_i,
    output logic [W-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        if (dir_i == DIR_DOWN) begin
            data_o = {data_i[W-2:0], fill_i};
        end else begin
            data_o = {fill_i, data_i[W-1:1]};
        end
    end

endmodule

// File: rtl/cht_lane_unshift.sv
// Sequential lane unshifter: undoes a STEPS-lane shift one lane per clock behind valid/ready.
// Optional parity check on the accepted word when CHT_UNSHIFT_PARITY_EN is defined.
module cht_lane_unshift
    import cht_unshift_pkg::*;
#(
    parameter  int unsigned W         = 36,
    parameter  int unsigned MAX_STEPS = 8,
    localparam int unsigned SW        = $clog2(MAX_STEPS + 1)
) (
    input  logic          pclk,
    input  logic          prst_n,
    input  logic          phold,
    input  logic          pin_valid,
    output logic          pin_ready,
    input  logic [W-1:0]  pin_data,
    input  logic          pin_dir,
    input  logic [SW-1:0] pin_steps,
    input  logic          pin_fill,
    input  logic          pin_par,
    output logic          pout_valid,
    input  logic          pout_ready,
    output logic [W-1:0]  pout_data,
    output logic          pout_err
);

    // Handshake: a word moves on an edge where valid & ready are both high;
    // phold drops pin_ready and blocks the output transfer, valid levels persist.
    state_e        state_q, state_d;
    logic [SW-1:0] count_q, count_d;
    logic [W-1:0]  data_q, data_d;
    logic          dir_q, dir_d;
    logic          fill_q, fill_d;
    logic [W-1:0]  step_data;
    logic          accept;
    logic          drain;

    cht_lane_step #(.W(W)) u_step (
        .data_i (data_q),
        .dir_i  (dir_q),
        .fill_i (fill_q),
        .data_o (step_data)
    );

    assign pin_ready  = (state_q == IDLE) && !phold;
    assign pout_valid = (state_q == DONE);
    assign pout_data  = data_q;
    assign accept     = pin_valid && pin_ready;
    assign drain      = pout_valid && pout_ready && !phold;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        data_d  = data_q;
        dir_d   = dir_q;
        fill_d  = fill_q;
        if (!phold) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        data_d  = pin_data;
                        dir_d   = pin_dir;
                        fill_d  = pin_fill;
                        count_d = SW'(clamp_steps({{(32-SW){1'b0}}, pin_steps}, MAX_STEPS));
                        state_d = (count_d == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    data_d  = step_data;
                    count_d = count_q - SW'(1);
                    if (count_q == SW'(1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (drain) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            data_q  <= '0;
            dir_q   <= DIR_UP;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
            fill_q  <= fill_d;
        end
    end

`ifdef CHT_UNSHIFT_PARITY_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (!phold) begin
            if (accept) begin
                err_d = (^pin_data) ^ pin_par;
            end else if (drain) begin
                err_d = 1'b0;
            end
        end
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign pout_err = err_q && (state_q == DONE);
`else
    logic unused_par;
    assign unused_par = pin_par;
    assign pout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_cht_lane_unshift.sv
// Directed bench for cht_lane_unshift: vector table plus reset, backpressure and hold sequences.
module tb_cht_lane_unshift;

    localparam int W  = 36;
    localparam int SW = 4;

    logic          pclk;
    logic          prst_n;
    logic          phold;
    logic          pin_valid;
    logic          pin_ready;
    logic [W-1:0]  pin_data;
    logic          pin_dir;
    logic [SW-1:0] pin_steps;
    logic          pin_fill;
    logic          pin_par;
    logic          pout_valid;
    logic          pout_ready;
    logic [W-1:0]  pout_data;
    logic          pout_err;

    int n_cmp = 0;
    int n_err = 0;

    cht_lane_unshift #(.W(W), .MAX_STEPS(8)) dut (
        .pclk       (pclk),
        .prst_n     (prst_n),
        .phold      (phold),
        .pin_valid  (pin_valid),
        .pin_ready  (pin_ready),
        .pin_data   (pin_data),
        .pin_dir    (pin_dir),
        .pin_steps  (pin_steps),
        .pin_fill   (pin_fill),
        .pin_par    (pin_par),
        .pout_valid (pout_valid),
        .pout_ready (pout_ready),
        .pout_data  (pout_data),
        .pout_err   (pout_err)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic [W-1:0]  data;
        logic          dir;
        logic [SW-1:0] steps;
        logic          fill;
        logic          par;
        logic [W-1:0]  exp_data;
        int            exp_lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_err_of(input logic [W-1:0] d, input logic par);
`ifdef CHT_UNSHIFT_PARITY_EN
        return (^d) ^ par;
`else
        return 1'b0;
`endif
    endfunction

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic accept_word(input logic [W-1:0] d, input logic dir, input logic [SW-1:0] st,
                               input logic fl, input logic par);
        int n = 0;
        while (!pin_ready && n < 200) begin
            @(negedge pclk);
            n++;
        end
        check("accept ready", pin_ready, 1'b1);
        pin_valid = 1'b1;
        pin_data  = d;
        pin_dir   = dir;
        pin_steps = st;
        pin_fill  = fl;
        pin_par   = par;
        @(negedge pclk);
        pin_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!pout_valid && lat < 100) begin
            @(negedge pclk);
            lat++;
        end
    endtask

    task automatic drain_word(input string name);
        pout_ready = 1'b1;
        @(negedge pclk);
        pout_ready = 1'b0;
        check({name, " valid after drain"}, pout_valid, 1'b0);
        check({name, " ready after drain"}, pin_ready, 1'b1);
    endtask

    initial begin
        int lat;
        int seen;
        logic [W-1:0] held;

        prst_n = 1'b0; phold = 1'b0; pin_valid = 1'b0; pin_data = '0; pin_dir = 1'b0;
        pin_steps = '0; pin_fill = 1'b0; pin_par = 1'b0; pout_ready = 1'b0;

        vecs[0] = '{36'h0_0000_000F, 1'b1, 4'd4,  1'b0, 1'b0, 36'h0_0000_00F0, 4};
        vecs[1] = '{36'hA_5A5A_5A5A, 1'b1, 4'd0,  1'b0, 1'b0, 36'hA_5A5A_5A5A, 0};
        vecs[2] = '{36'h0_0000_0000, 1'b0, 4'd15, 1'b1, 1'b0, 36'hF_F000_0000, 8};
        vecs[3] = '{36'h0_0000_0001, 1'b1, 4'd0,  1'b0, 1'b0, 36'h0_0000_0001, 0};
        vecs[4] = '{36'h0_0000_0001, 1'b1, 4'd0,  1'b0, 1'b1, 36'h0_0000_0001, 0};
        vecs[5] = '{36'h8_0000_0001, 1'b1, 4'd1,  1'b1, 1'b0, 36'h0_0000_0003, 1};
        vecs[6] = '{36'hF_FFFF_FFFF, 1'b0, 4'd8,  1'b0, 1'b0, 36'h0_0FFF_FFFF, 8};
        vecs[7] = '{36'h0_0000_0001, 1'b1, 4'd9,  1'b0, 1'b1, 36'h0_0000_0100, 8};
        vecs[8] = '{36'h0_0000_0000, 1'b1, 4'd3,  1'b1, 1'b0, 36'h0_0000_0007, 3};

        // Reset state
        #12;
        check("reset pout_valid", pout_valid, 1'b0);
        check("reset pout_data", pout_data, '0);
        check("reset pout_err", pout_err, 1'b0);
        @(negedge pclk);
        prst_n = 1'b1;
        @(negedge pclk);
        check("ready after release", pin_ready, 1'b1);

        for (int i = 0; i < 9; i++) begin
            accept_word(vecs[i].data, vecs[i].dir, vecs[i].steps, vecs[i].fill, vecs[i].par);
            wait_valid(lat);
            check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d data", i), pout_data, vecs[i].exp_data);
            check($sformatf("vec%0d err", i), pout_err, exp_err_of(vecs[i].data, vecs[i].par));
            check($sformatf("vec%0d ready in DONE", i), pin_ready, 1'b0);
            drain_word($sformatf("vec%0d", i));
        end

        // Reset mid-SHIFT drops the word
        accept_word(36'h0_0000_0001, 1'b1, 4'd8, 1'b0, 1'b0);
        @(negedge pclk);
        @(negedge pclk);
        #2 prst_n = 1'b0;
        #1;
        check("midshift rst valid", pout_valid, 1'b0);
        check("midshift rst data", pout_data, '0);
        @(negedge pclk);
        prst_n = 1'b1;
        @(negedge pclk);
        check("midshift ready after release", pin_ready, 1'b1);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (pout_valid) seen++;
            @(negedge pclk);
        end
        check("midshift no output", seen, 0);

        // Backpressure in DONE
        accept_word(36'h0_0000_0003, 1'b1, 4'd2, 1'b0, 1'b0);
        wait_valid(lat);
        check("bp latency", lat, 2);
        for (int k = 0; k < 5; k++) begin
            @(negedge pclk);
            check($sformatf("bp data c%0d", k), pout_data, 36'h0_0000_000C);
            check($sformatf("bp valid c%0d", k), pout_valid, 1'b1);
            check($sformatf("bp ready c%0d", k), pin_ready, 1'b0);
        end
        drain_word("bp");

        // Hold for 3 cycles mid-SHIFT stretches latency by 3
        accept_word(36'h0_0000_0001, 1'b1, 4'd6, 1'b0, 1'b0);
        lat = 0;
        while (!pout_valid && lat < 100) begin
            phold = (lat >= 2 && lat < 5);
            #1;
            if (phold) check($sformatf("hold ready c%0d", lat), pin_ready, 1'b0);
            @(negedge pclk);
            lat++;
        end
        phold = 1'b0;
        check("hold latency", lat, 9);
        check("hold data", pout_data, 36'h0_0000_0040);

        // Hold in DONE blocks the output transfer
        held = pout_data;
        phold = 1'b1;
        pout_ready = 1'b1;
        @(negedge pclk);
        check("hold done valid", pout_valid, 1'b1);
        check("hold done data", pout_data, held);
        check("hold done ready", pin_ready, 1'b0);
        phold = 1'b0;
        pout_ready = 1'b0;
        drain_word("hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
